mps_sfp_link_ctrl: RTL
======================

// Module: mps_sfp_link_ctrl
// PURPOSE
//  Parametrised SFP link controller for the MPS core. Sits between the AXI4-Lite register
//  bank and the Aurora wrapper. Replaces the fixed 3-slave/7-frame exchange with N slaves
//  of F frames each, a per-slave enable mask and master/slave modes. Adds periodic master
//  scheduling, a response timeout and sticky error/statistics outputs.
// PARAMETERS
//  C_AXIS_TDATA_WIDTH  64     width of one frame word
//  C_NUMBER_OF_SLAVE   3      slave count N (1..8)
//  C_NUMBER_OF_FRAME   7      frames per slave F
//  C_PERIOD_CYCLES     10000  master exchange period, in i_clk cycles (>=8)
//  C_TIMEOUT_CYCLES    2000   max wait for rx end flag; slave-mode rx watchdog (< C_PERIOD_CYCLES)
//  (derived) FB = C_AXIS_TDATA_WIDTH*C_NUMBER_OF_FRAME; SB = FB*C_NUMBER_OF_SLAVE
// PORTS
//  i_clk              in   1    system clock (AXI clock domain)
//  i_rst              in   1    asynchronous, active-low reset
//  i_sfp_m_en         in   1    1 = master mode, 0 = slave mode
//  i_run              in   1    link enable
//  i_slave_en         in   N    per-slave enable mask
//  i_err_clr          in   1    clears the sticky error flags (pulse)
//  i_axi_data         in   SB   tx payload from the register bank
//  o_axi_data         out  SB   last captured rx payload
//  o_axi_data_valid   out  1    1-cycle pulse: o_axi_data has been updated
//  o_stream_data      out  SB   payload to Aurora tx
//  i_stream_data      in   SB   payload from Aurora rx
//  o_sfp_start_flag   out  1    1-cycle tx start pulse
//  i_sfp_end_flag     in   1    rx complete pulse
//  o_err_flags        out  2    sticky {overrun, timeout}
//  o_timeout_cnt      out  16   timeout count; saturates at 16'hFFFF
//  o_cycle_cnt        out  32   completed exchanges; wraps
//  o_state            out  3    FSM state, for debug
// BEHAVIOUR
//  Reset: every output is 0, FSM in IDLE, and the period and timeout counters are 0.
//  Reset takes effect immediately, including mid-transfer. No partial data is kept.
//  Slave k occupies bits [k*FB +: FB] of every SB-wide bus.
//  States: IDLE=0, LOAD=1, START=2, WAIT=3, CAPTURE=4.
//  i_sfp_m_en and i_run are sampled only in IDLE. Clearing i_run mid-exchange lets the
//  exchange finish.
//  Master period counter:
//   - Runs 0..C_PERIOD_CYCLES-1 while i_run=1 and i_sfp_m_en=1; otherwise held at 0.
//   - Terminal count (tick) in IDLE: go to LOAD.
//   - Tick in any other state: set overrun flag; the tick is dropped.
//  Master sequence:
//   - LOAD (1 cyc): o_stream_data <= i_axi_data, with slices of disabled slaves forced to 0.
//   - START (1 cyc): o_sfp_start_flag = 1.
//   - WAIT: timeout counter increments from 0 each cycle.
//     i_sfp_end_flag=1: go to CAPTURE.
//     Counter reaches C_TIMEOUT_CYCLES-1 without end flag: set timeout flag,
//     o_timeout_cnt+1, go to IDLE. o_axi_data unchanged, no valid pulse.
//     End flag on the same cycle as the timeout terminal: the end flag wins.
//   - CAPTURE (1 cyc): enabled slices of o_axi_data <= i_stream_data; disabled slices <= 0.
//     On the CAPTURE->IDLE edge, o_axi_data_valid is high for exactly 1 cycle and
//     o_cycle_cnt is incremented.
//   - Master latency: tick -> start pulse = 2 cycles; end flag -> valid = 2 cycles.
//  Slave sequence: IDLE --end flag--> CAPTURE -> LOAD -> START -> IDLE (echo reply).
//   - No WAIT state in slave mode.
//   - Rx watchdog: the timeout counter counts in IDLE. At C_TIMEOUT_CYCLES-1 it sets the
//     timeout flag, increments o_timeout_cnt once and holds until the next end flag.
//  Master-mode end flag outside WAIT: ignored.
//  i_err_clr clears both flags. If it arrives on the same cycle as a new error, the set wins.
//  If i_slave_en changes mid-exchange, the value is used as sampled at LOAD/CAPTURE.
// TESTING
//  1 Master, N=3, F=7, all slaves enabled. end flag 10 cyc after start
//    -> one start pulse per 10000 cyc; o_axi_data == i_stream_data; valid 2 cyc after end;
//    o_cycle_cnt=1.
//  2 Master, i_slave_en=3'b101
//    -> o_stream_data[FB +: FB]==0 and o_axi_data[FB +: FB]==0; other slices pass through.
//  3 Master, no end flag
//    -> IDLE after 2000 WAIT cyc; o_err_flags=2'b01; o_timeout_cnt=1; no valid pulse;
//    the next tick still starts an exchange.
//  4 Slave mode, end flag pulse
//    -> valid pulse; start pulse 3 cyc after end; o_stream_data == masked i_axi_data;
//    3000 idle cyc -> timeout set exactly once.
//  5 Master, C_PERIOD_CYCLES=8, C_TIMEOUT_CYCLES=2 (both override defaults), no end flag;
//    then i_err_clr coincident with a new timeout
//    -> flags remain set (set wins).
//  6 Assert i_rst in WAIT
//    -> all outputs 0 at once. Release rst, next tick -> normal exchange.
//    Also: force o_timeout_cnt to 16'hFFFF -> it saturates, no wrap.

Source files
------------

// File: rtl/mps_sfp_link_ctrl.sv
// SFP link controller between the register bank and the Aurora wrapper.
// Master mode: a free-running period counter launches LOAD -> START -> WAIT -> CAPTURE
// exchanges and flags overruns/timeouts. Slave mode: an incoming end flag is captured
// and echoed back (CAPTURE -> LOAD -> START), with an rx watchdog counting idle time.
// Slave k owns bits [k*FB +: FB] of every payload bus; disabled slices read as zero.
module mps_sfp_link_ctrl #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_NUMBER_OF_SLAVE  = 3,
    parameter int C_NUMBER_OF_FRAME  = 7,
    parameter int C_PERIOD_CYCLES    = 10000,
    parameter int C_TIMEOUT_CYCLES   = 2000,
    localparam int FB = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_FRAME,
    localparam int SB = FB * C_NUMBER_OF_SLAVE
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_sfp_m_en,
    input  logic                         i_run,
    input  logic [C_NUMBER_OF_SLAVE-1:0] i_slave_en,
    input  logic                         i_err_clr,
    input  logic [SB-1:0]                i_axi_data,
    output logic [SB-1:0]                o_axi_data,
    output logic                         o_axi_data_valid,
    output logic [SB-1:0]                o_stream_data,
    input  logic [SB-1:0]                i_stream_data,
    output logic                         o_sfp_start_flag,
    input  logic                         i_sfp_end_flag,
    output logic [1:0]                   o_err_flags,
    output logic [15:0]                  o_timeout_cnt,
    output logic [31:0]                  o_cycle_cnt,
    output logic [2:0]                   o_state
);

    localparam int PW = (C_PERIOD_CYCLES > 1) ? $clog2(C_PERIOD_CYCLES) : 1;
    // One extra code above the terminal value lets the slave watchdog park after firing.
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(C_PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(C_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_HOLD    = TW'(C_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    state_t          state_reg;
    logic            master_mode_reg;
    logic [PW-1:0]   period_cnt_reg;
    logic [TW-1:0]   tmo_cnt_reg;
    logic [SB-1:0]   axi_data_reg;
    logic            axi_valid_reg;
    logic [SB-1:0]   stream_data_reg;
    logic            start_reg;
    logic [1:0]      err_flags_reg;
    logic [15:0]     timeout_cnt_reg;
    logic [31:0]     cycle_cnt_reg;

    logic [SB-1:0]   en_mask;
    logic            period_run;
    logic            tick;
    logic            slave_idle;
    logic            wait_expire;
    logic            watchdog_expire;
    logic            timeout_evt;
    logic            overrun_evt;

    // Expand the per-slave enable bits into a full-width payload mask.
    genvar gi;
    generate
        for (gi = 0; gi < C_NUMBER_OF_SLAVE; gi++) begin : g_mask
            assign en_mask[gi*FB +: FB] = {FB{i_slave_en[gi]}};
        end
    endgenerate

    assign period_run      = i_run & i_sfp_m_en;
    assign tick            = period_run && (period_cnt_reg == PERIOD_LAST);
    assign slave_idle      = i_run & ~i_sfp_m_en;
    // An end flag on the terminal cycle beats the timeout.
    assign wait_expire     = (state_reg == ST_WAIT) && !i_sfp_end_flag && (tmo_cnt_reg == TMO_LAST);
    assign watchdog_expire = (state_reg == ST_IDLE) && slave_idle && !i_sfp_end_flag
                             && (tmo_cnt_reg == TMO_LAST);
    assign timeout_evt     = wait_expire | watchdog_expire;
    // A tick that finds an exchange still in flight is dropped and reported.
    assign overrun_evt     = tick && (state_reg != ST_IDLE);

    // Master period counter: free-runs only while enabled in master mode.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            period_cnt_reg <= '0;
        end else if (!period_run || period_cnt_reg == PERIOD_LAST) begin
            period_cnt_reg <= '0;
        end else begin
            period_cnt_reg <= period_cnt_reg + 1'b1;
        end
    end

    // Exchange sequencer with registered payload, strobe and timeout-counter outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg       <= ST_IDLE;
            master_mode_reg <= 1'b0;
            tmo_cnt_reg     <= '0;
            axi_data_reg    <= '0;
            axi_valid_reg   <= 1'b0;
            stream_data_reg <= '0;
            start_reg       <= 1'b0;
            cycle_cnt_reg   <= '0;
        end else begin
            start_reg     <= 1'b0;
            axi_valid_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (tick) begin
                        master_mode_reg <= 1'b1;
                        tmo_cnt_reg     <= '0;
                        state_reg       <= ST_LOAD;
                    end else if (slave_idle) begin
                        if (i_sfp_end_flag) begin
                            master_mode_reg <= 1'b0;
                            tmo_cnt_reg     <= '0;
                            state_reg       <= ST_CAPTURE;
                        end else if (tmo_cnt_reg == TMO_LAST) begin
                            tmo_cnt_reg <= TMO_HOLD;
                        end else if (tmo_cnt_reg != TMO_HOLD) begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                    end else begin
                        tmo_cnt_reg <= '0;
                    end
                end
                ST_LOAD: begin
                    stream_data_reg <= i_axi_data & en_mask;
                    start_reg       <= 1'b1;
                    state_reg       <= ST_START;
                end
                ST_START: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= master_mode_reg ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (i_sfp_end_flag) begin
                        state_reg <= ST_CAPTURE;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        tmo_cnt_reg <= '0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    axi_data_reg  <= i_stream_data & en_mask;
                    axi_valid_reg <= 1'b1;
                    cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
                    tmo_cnt_reg   <= '0;
                    state_reg     <= master_mode_reg ? ST_IDLE : ST_LOAD;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags (a coincident set beats the clear) and saturating timeout count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            err_flags_reg   <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            err_flags_reg <= (err_flags_reg & {2{~i_err_clr}}) | {overrun_evt, timeout_evt};
            if (timeout_evt && timeout_cnt_reg != 16'hFFFF) begin
                timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
            end
        end
    end

    assign o_axi_data       = axi_data_reg;
    assign o_axi_data_valid = axi_valid_reg;
    assign o_stream_data    = stream_data_reg;
    assign o_sfp_start_flag = start_reg;
    assign o_err_flags      = err_flags_reg;
    assign o_timeout_cnt    = timeout_cnt_reg;
    assign o_cycle_cnt      = cycle_cnt_reg;
    assign o_state          = state_reg;

endmodule
